stopwatch_core_param: RTL and testbench
=======================================

Name: stopwatch_core_param

Overview:
Parametrised MM:SS stopwatch core driving a 4-digit multiplexed seven-segment display.
- Successor to the fixed-rate lab stopwatch.
- Tick, adjust, scan and minute-wrap limits are parameters, so benches run with small values and the board build uses real rates.
- Adds a run/hold/adjust state machine, field-select blinking, a wrap strobe and a BCD time bus for verification.
- Sits directly under the board top; pause is already debounced and synchronised upstream.

Parameters:
TICK_CYC, 100000000, clk cycles per count tick (1 Hz at 100 MHz); must be >= 2
ADJ_CYC, 50000000, clk cycles per adjust increment / blink toggle (2 Hz); must be >= 2
SCAN_CYC, 100000, clk cycles per display digit slot; must be >= 2
MAX_MIN, 59, highest minute value before wrap; range 1..99

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pause  in  1  single-cycle pulse; toggles run/hold
sw  in  2  sw[0]=adjust mode, sw[1]=field select (0 seconds, 1 minutes)
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low, registered
digit  out  4  anodes, active-low one-hot, registered
time_bcd  out  16  {min_tens,min_ones,sec_tens,sec_ones}, registered
wrap  out  1  one-cycle pulse on MAX_MIN:59 -> 00:00 rollover in RUN

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - state=RUN, time_bcd=16'h0000, wrap=0, seg=7'h7F, digit=4'b1111.
  - All dividers at 0, blink=0, scan index=0.
- Tick generator:
  - Counter runs 0..TICK_CYC-1 only in RUN; tick pulses on the cycle it equals TICK_CYC-1, then returns to 0.
  - Held at 0 in HOLD/ADJ, so the first increment after resume lands exactly TICK_CYC cycles later.
- Adjust generator:
  - Counter runs 0..ADJ_CYC-1 only in ADJ, same pulse rule; cleared on ADJ entry.
  - Scan counter always free-runs.
- States RUN, HOLD, ADJ:
  - RUN --pause--> HOLD; HOLD --pause--> RUN.
  - RUN/HOLD --sw[0]=1--> ADJ; ADJ --sw[0]=0--> HOLD.
  - pause is ignored in ADJ. If pause and sw[0] rise in the same cycle, ADJ wins.
- Counting (RUN, on tick):
  - BCD increment with carry: sec_ones 0-9, sec_tens 0-5, min 00..MAX_MIN.
  - At MAX_MIN:59 the next value is 00:00, and wrap=1 for exactly the following cycle (registered alongside time_bcd).
  - time_bcd updates 1 cycle after the tick pulse.
- Adjust (ADJ, on adjust pulse):
  - Selected field +1 with no carry. Seconds wrap 59->00; minutes wrap MAX_MIN->00.
  - wrap stays 0. sw[1] is sampled each pulse and may change mid-ADJ.
- Blink:
  - Toggles on each adjust pulse; cleared on ADJ entry.
  - In ADJ with blink=1, both digits of the selected field display blank (seg=7'h7F, anode still driven).
- Display scan:
  - 2-bit index increments on each scan pulse.
  - idx0 sec_ones digit=4'b1110; idx1 sec_tens 4'b1101; idx2 min_ones 4'b1011; idx3 min_tens 4'b0111.
  - seg and digit register together from the index and current time_bcd (1-cycle latency); never out of step.
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Non-BCD values are unreachable; decode them to 7F.
- Reset mid-count: outputs go to their reset values asynchronously; no wrap pulse is produced.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when min_tens==0, the idx3 slot shows seg=7'h7F in every state (the digit anode is still driven).
- Undefined: min_tens shows 0 normally.
- time_bcd is unaffected either way.

Test Plan:
1. Bench params TICK_CYC=10, ADJ_CYC=4, SCAN_CYC=2, MAX_MIN=59. Release reset, run 600 clk -> time_bcd=16'h0100; wrap never asserted.
2. Adjust to 59:59 (sw=2'b11 to set min 59, sw=2'b01 to set sec 59), sw=0, pause pulse -> RUN. Exactly 10 clk later time_bcd=16'h0000 and wrap=1 for one cycle.
3. In RUN at 00:05, pause pulse -> value frozen for 200 clk. Second pause -> 00:06 exactly 10 clk after resume (+1 register cycle).
4. sw=2'b01 from 00:58, 3 adjust pulses (12 clk) -> 00:01; minutes unchanged. Selected digits blank on alternate pulses. pause pulses are ignored.
5. Hold 12:34, observe the scan -> digit/seg pairs 1110/19, 1101/30, 1011/24, 0111/79 in repeating order. Under LEADING_ZERO_BLANK_EN with 02:34, the idx3 slot shows seg=7F.
6. Assert reset asynchronously mid-count at 03:27 between clk edges -> outputs at reset values before the next edge. After release, state=RUN and counting restarts from 00:00.

Source files
------------

// File: rtl/stopwatch_core_param.sv
// Parametrised MM:SS stopwatch core with RUN/HOLD/ADJ control and 4-digit multiplexed display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the minute-tens digit while it is zero.
module stopwatch_core_param #(
  parameter int TICK_CYC = 100000000,
  parameter int ADJ_CYC  = 50000000,
  parameter int SCAN_CYC = 100000,
  parameter int MAX_MIN  = 59
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic [1:0]  sw,
  output logic [6:0]  seg,
  output logic [3:0]  digit,
  output logic [15:0] time_bcd,
  output logic        wrap
);

  localparam int TICK_W = $clog2(TICK_CYC);
  localparam int ADJ_W  = $clog2(ADJ_CYC);
  localparam int SCAN_W = $clog2(SCAN_CYC);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
  localparam logic [ADJ_W-1:0]  ADJ_LAST  = ADJ_W'(ADJ_CYC - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);

  localparam logic [7:0] MIN_LAST = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    ADJ  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [TICK_W-1:0] tick_cnt;
  logic [ADJ_W-1:0]  adj_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic              tick;
  logic              adj_pulse;
  logic              scan_pulse;
  logic              blink;
  logic [1:0]        scan_idx;

  logic [15:0] time_next;
  logic        wrap_next;
  logic [3:0]  shown_val;
  logic        shown_blank;
  logic [6:0]  seg_next;
  logic [3:0]  digit_next;

  function automatic logic [6:0] decode(input logic [3:0] val);
    case (val)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    if (s == 8'h59)
      sec_inc = 8'h00;
    else if (s[3:0] == 4'd9)
      sec_inc = {s[7:4] + 4'd1, 4'd0};
    else
      sec_inc = {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m == MIN_LAST)
      min_inc = 8'h00;
    else if (m[3:0] == 4'd9)
      min_inc = {m[7:4] + 4'd1, 4'd0};
    else
      min_inc = {m[7:4], m[3:0] + 4'd1};
  endfunction

  // Adjust mode takes priority over a simultaneous pause pulse; pause is ignored inside ADJ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    case (state)
      RUN:     if (sw[0]) state_next = ADJ;
               else if (pause) state_next = HOLD;
      HOLD:    if (sw[0]) state_next = ADJ;
               else if (pause) state_next = RUN;
      ADJ:     if (!sw[0]) state_next = HOLD;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  assign tick       = (state == RUN) && (tick_cnt == TICK_LAST);
  assign adj_pulse  = (state == ADJ) && (adj_cnt == ADJ_LAST);
  assign scan_pulse = (scan_cnt == SCAN_LAST);

  // Dividers sit at zero outside their active state, so resume/entry restarts a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      adj_cnt  <= '0;
      scan_cnt <= '0;
      scan_idx <= 2'd0;
      blink    <= 1'b0;
    end else begin
      if (state != RUN || tick) tick_cnt <= '0;
      else                      tick_cnt <= tick_cnt + TICK_W'(1);

      if (state != ADJ || adj_pulse) adj_cnt <= '0;
      else                           adj_cnt <= adj_cnt + ADJ_W'(1);

      if (scan_pulse) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      if (state != ADJ) blink <= 1'b0;
      else if (adj_pulse) blink <= ~blink;
    end
  end

  // Counting carries seconds into minutes; adjusting bumps one field without carry.
  always_comb begin
    time_next = time_bcd;
    wrap_next = 1'b0;
    if (tick) begin
      if (time_bcd[7:0] == 8'h59) begin
        time_next[7:0]  = 8'h00;
        time_next[15:8] = min_inc(time_bcd[15:8]);
        wrap_next       = (time_bcd[15:8] == MIN_LAST);
      end else begin
        time_next[7:0] = sec_inc(time_bcd[7:0]);
      end
    end else if (adj_pulse) begin
      if (sw[1]) time_next[15:8] = min_inc(time_bcd[15:8]);
      else       time_next[7:0]  = sec_inc(time_bcd[7:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_bcd <= 16'h0000;
      wrap     <= 1'b0;
    end else begin
      time_bcd <= time_next;
      wrap     <= wrap_next;
    end
  end

  // Slot 0/1 carry seconds, 2/3 carry minutes; blink blanks the field being adjusted.
  always_comb begin
    shown_val   = time_bcd[3:0];
    shown_blank = 1'b0;
    case (scan_idx)
      2'd0:    shown_val = time_bcd[3:0];
      2'd1:    shown_val = time_bcd[7:4];
      2'd2:    shown_val = time_bcd[11:8];
      default: shown_val = time_bcd[15:12];
    endcase
    if (state == ADJ && blink && (sw[1] == scan_idx[1]))
      shown_blank = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if (scan_idx == 2'd3 && time_bcd[15:12] == 4'd0)
      shown_blank = 1'b1;
`endif
    seg_next   = shown_blank ? 7'h7F : decode(shown_val);
    digit_next = ~(4'b0001 << scan_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg   <= 7'h7F;
      digit <= 4'b1111;
    end else begin
      seg   <= seg_next;
      digit <= digit_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_core_param.sv
// Directed bench for stopwatch_core_param with small rates (tick 10, adjust 4, scan 2, max minute 59).
// The display model follows LEADING_ZERO_BLANK_EN when the bench is built with that macro.
module tb_stopwatch_core_param;

  logic        clk;
  logic        reset;
  logic        pause;
  logic [1:0]  sw;
  logic [6:0]  seg;
  logic [3:0]  digit;
  logic [15:0] time_bcd;
  logic        wrap;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  int unsigned cyc = 0;

  stopwatch_core_param #(
    .TICK_CYC(10),
    .ADJ_CYC (4),
    .SCAN_CYC(2),
    .MAX_MIN (59)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pause   (pause),
    .sw      (sw),
    .seg     (seg),
    .digit   (digit),
    .time_bcd(time_bcd),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release; drives the expected scan slot.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pause_pulse();
    pause = 1'b1;
    step(1);
    pause = 1'b0;
  endtask

  task automatic wait_time(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (time_bcd !== target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, time_bcd, target);
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'h40; 4'd1: dec = 7'h79; 4'd2: dec = 7'h24; 4'd3: dec = 7'h30;
      4'd4: dec = 7'h19; 4'd5: dec = 7'h12; 4'd6: dec = 7'h02; 4'd7: dec = 7'h78;
      4'd8: dec = 7'h00; 4'd9: dec = 7'h10; default: dec = 7'h7F;
    endcase
  endfunction

  // t/blink_on describe the cycle before the current sample (registered display).
  task automatic check_disp(input logic [15:0] t, input bit blink_on, input bit field_min);
    int unsigned idx;
    logic [3:0] nib;
    logic [6:0] exp_seg;
    logic [3:0] exp_digit;
    idx = ((cyc - 1) / 2) % 4;
    case (idx)
      0:       nib = t[3:0];
      1:       nib = t[7:4];
      2:       nib = t[11:8];
      default: nib = t[15:12];
    endcase
    exp_seg = dec(nib);
    if (blink_on && (field_min == (idx >= 2))) exp_seg = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3 && t[15:12] == 4'd0) exp_seg = 7'h7F;
`endif
    exp_digit = ~(4'b0001 << idx);
    check("digit", {12'h000, digit}, {12'h000, exp_digit});
    check("seg", {9'h000, seg}, {9'h000, exp_seg});
  endtask

  initial begin
    reset = 1'b1;
    pause = 1'b0;
    sw    = 2'b00;
    step(3);
    check("rst_time", time_bcd, 16'h0000);
    check("rst_seg", {9'h000, seg}, 16'h007F);
    check("rst_digit", {12'h000, digit}, 16'h000F);
    check("rst_wrap", {15'h0, wrap}, 16'h0000);
    reset = 1'b0;

    // 1: free run 600 cycles
    step(1);
    check_disp(16'h0000, 1'b0, 1'b0);
    step(598);
    check("run_599", time_bcd, 16'h0059);
    step(1);
    check("run_600", time_bcd, 16'h0100);
    check("no_wrap_run", wrap_cnt[15:0], 16'd0);

    // 2: adjust to 59:59, resume, rollover
    sw = 2'b11;
    wait_time(16'h5900, 300, "adj_min59");
    sw = 2'b01;
    wait_time(16'h5959, 300, "adj_sec59");
    check("no_wrap_adj", wrap_cnt[15:0], 16'd0);
    sw = 2'b00;
    step(1);
    pause_pulse();
    step(9);
    check("pre_wrap_time", time_bcd, 16'h5959);
    check("pre_wrap", {15'h0, wrap}, 16'h0000);
    step(1);
    check("wrap_time", time_bcd, 16'h0000);
    check("wrap_hi", {15'h0, wrap}, 16'h0001);
    step(1);
    check("wrap_lo", {15'h0, wrap}, 16'h0000);
    check("wrap_once", wrap_cnt[15:0], 16'd1);

    // 3: hold and resume
    wait_time(16'h0005, 100, "reach_0005");
    pause_pulse();
    step(200);
    check("hold_frozen", time_bcd, 16'h0005);
    pause_pulse();
    step(9);
    check("resume_9", time_bcd, 16'h0005);
    step(1);
    check("resume_10", time_bcd, 16'h0006);

    // 4: seconds adjust 58 -> 01 with blink, pause ignored
    wait_time(16'h0058, 600, "reach_0058");
    sw = 2'b01;
    for (int j = 0; j <= 12; j++) begin
      pause = (j == 6);
      step(1);
      if (j >= 1) begin
        logic [15:0] tp;
        tp = (j - 1 < 4) ? 16'h0058 : (j - 1 < 8) ? 16'h0059 : 16'h0000;
        check_disp(tp, (j - 1 >= 4) && (j - 1 < 8), 1'b0);
      end
      if (j == 4) check("adj_p1", time_bcd, 16'h0059);
      if (j == 8) check("adj_p2", time_bcd, 16'h0000);
    end
    pause = 1'b0;
    check("adj_p3", time_bcd, 16'h0001);
    check("no_wrap_adj2", wrap_cnt[15:0], 16'd1);

    // 5: scan in HOLD at 12:34 and 02:34
    sw = 2'b11;
    wait_time(16'h1201, 200, "set_1201");
    sw = 2'b01;
    wait_time(16'h1234, 300, "set_1234");
    sw = 2'b00;
    step(3);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_disp(16'h1234, 1'b0, 1'b0);
    end
    sw = 2'b11;
    wait_time(16'h0234, 300, "set_0234");
    sw = 2'b00;
    step(3);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_disp(16'h0234, 1'b0, 1'b0);
    end

    // 6: async reset mid-count at 03:27
    sw = 2'b11;
    wait_time(16'h0334, 50, "set_0334");
    sw = 2'b01;
    wait_time(16'h0327, 300, "set_0327");
    sw = 2'b00;
    step(1);
    pause_pulse();
    step(5);
    check("mid_count", time_bcd, 16'h0327);
    #2 reset = 1'b1;
    #1;
    check("async_time", time_bcd, 16'h0000);
    check("async_seg", {9'h000, seg}, 16'h007F);
    check("async_digit", {12'h000, digit}, 16'h000F);
    check("async_wrap", {15'h0, wrap}, 16'h0000);
    step(1);
    reset = 1'b0;
    step(1);
    check_disp(16'h0000, 1'b0, 1'b0);
    step(8);
    check("restart_9", time_bcd, 16'h0000);
    step(1);
    check("restart_10", time_bcd, 16'h0001);
    check("no_wrap_rst", wrap_cnt[15:0], 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
